dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/debug loader port.
- The CPU has priority. The DMA port is served in cycles where the CPU MEM stage makes no access.
- A starvation counter forces a short DMA burst, stalling the whole pipeline while the burst runs.
- Sits between the EX/MEM register outputs and the data memory; its stall output is ORed into the top-level pipeline freeze.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 8, consecutive blocked DMA-request cycles before a forced burst (must be ≥1).
- BURST_MAX, 4, maximum DMA beats granted per forced burst (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd  in  1  MEM-stage read request
- cpu_wr  in  1  MEM-stage write request
- cpu_addr  in  AW  MEM-stage address
- cpu_wdata  in  DW  MEM-stage write data
- cpu_rdata  out  DW  read data to MEM stage
- cpu_stall  out  1  freeze all pipeline stages this cycle
- dma_req  in  1  DMA access request (level)
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  DW  registered DMA read data
- dma_rvalid  out  1  dma_rdata valid (one-cycle pulse)
- mem_rd  out  1  to data memory
- mem_wr  out  1  to data memory
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_rdata  in  DW  from data memory (combinational read)

Behaviour:
- Memory model: combinational read; write commits on the rising clk edge when mem_wr=1.
- cpu_busy = cpu_rd | cpu_wr.
- States:
  - NORMAL: reset state.
  - FORCE: entered only after DMA starvation.
- Registers:
  - wait_cnt: width $clog2(MAX_WAIT+1), saturating.
  - beat_cnt: width $clog2(BURST_MAX+1).
  - dma_rdata, dma_rvalid.
- Reset (reset=0): state=NORMAL, wait_cnt=0, beat_cnt=0, dma_rdata=0, dma_rvalid=0. While reset=0, dma_gnt=0 and cpu_stall=0.
- dma_gnt (combinational):
  - NORMAL: dma_gnt = dma_req & ~cpu_busy.
  - FORCE: dma_gnt = dma_req.
- cpu_stall (combinational) = (state==FORCE) & dma_req & cpu_busy. It is never asserted in NORMAL.
- Memory mux:
  - dma_gnt=1: mem_addr=dma_addr, mem_wdata=dma_wdata, mem_wr=dma_we, mem_rd=~dma_we.
  - Otherwise: CPU fields pass through unchanged.
  - cpu_rdata = mem_rdata always. The CPU ignores it while stalled.
- DMA handshake:
  - The requester holds req/we/addr/wdata stable until it samples dma_gnt=1 at a rising edge. The transfer completes at that edge.
  - Read grant: dma_rdata <= mem_rdata at the grant edge; dma_rvalid=1 for the following cycle only.
  - Back-to-back grants yield back-to-back rvalid pulses.
- NORMAL transitions:
  - dma_gnt=1 → wait_cnt <= 0.
  - dma_req & cpu_busy → wait_cnt increments (saturating). If wait_cnt==MAX_WAIT-1 in this cycle → state <= FORCE, beat_cnt <= 0, wait_cnt <= 0.
  - dma_req=0 → wait_cnt <= 0. Starvation is counted over consecutive requesting cycles only.
- FORCE transitions:
  - Each grant → beat_cnt++.
  - Exit to NORMAL at the edge where dma_req=0, or where a grant makes beat_cnt reach BURST_MAX.
  - On exit: beat_cnt <= 0, wait_cnt <= 0.
- Simultaneous cpu_rd & cpu_wr: treated as a write on the memory side.
- Stall release: the stalled CPU access is re-presented unchanged in the first NORMAL cycle and is serviced then. The CPU never loses an access.
- Reset mid-burst: state returns to NORMAL at once. Any write not already committed is dropped. dma_rvalid clears.

Decomposition:
- Shared package:
  - state encoding (ST_NORMAL, ST_FORCE);
  - default MAX_WAIT and BURST_MAX constants;
  - the AW and DW defaults.
- One natural sub-module: dmem_arb_starve_ctr, holding the wait_cnt/beat_cnt logic and emitting force_enter and force_exit.
- The mux and handshake stay in the top-level module.

Test Plan:
1. CPU idle, DMA write to 0x100, data 0xDEADBEEF → dma_gnt=1 in the same cycle; memory holds 0xDEADBEEF after the edge; cpu_stall=0.
2. CPU idle, DMA read of 0x100 → dma_gnt=1; next cycle dma_rvalid=1 with dma_rdata=0xDEADBEEF, and rvalid clears one cycle later.
3. CPU busy every cycle, dma_req held, MAX_WAIT=8 → no grant for 8 cycles; FORCE is entered; then 4 cycles with cpu_stall=1 and dma_gnt=1; back to NORMAL; the CPU access is serviced in the next cycle.
4. In FORCE, dma_req drops after 2 beats → exit to NORMAL at that edge; cpu_stall deasserts the same cycle; beat_cnt=0.
5. CPU busy for 5 cycles, then idle for 1 cycle (DMA granted), then busy again → wait_cnt restarts at 0; no FORCE until 8 further blocked cycles.
6. Assert reset=0 during the second FORCE beat → dma_gnt=0, cpu_stall=0, dma_rvalid=0 immediately; state=NORMAL after release; no spurious memory write.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared definitions for the data-memory arbiter. Holds the
//               arbiter state encoding and the default widths and
//               starvation/burst limits used by dmem_arbiter and
//               dmem_arb_starve_ctr.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int DEFAULT_AW        = 32;
    localparam int DEFAULT_DW        = 32;
    localparam int DEFAULT_MAX_WAIT  = 8;
    localparam int DEFAULT_BURST_MAX = 4;

    // NORMAL: the CPU owns the memory and DMA only gets idle cycles.
    // FORCE : a starved DMA requester owns the memory and the pipeline stalls.
    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_starve_ctr
// Description : Starvation and burst-length bookkeeping for dmem_arbiter.
//               Counts consecutive cycles in which a DMA request is blocked by
//               the CPU and, once the limit is hit, requests entry into the
//               forced-burst state. While in the forced burst it counts the
//               granted beats and requests exit when the burst is complete or
//               the DMA requester goes idle.
// Ports       : clk         - system clock, rising edge
//               reset       - asynchronous active-low reset
//               in_force    - arbiter currently in the forced-burst state
//               dma_req     - DMA request level
//               cpu_busy    - CPU MEM stage is accessing memory this cycle
//               dma_gnt     - DMA access performed this cycle
//               force_enter - move to the forced-burst state at this edge
//               force_exit  - return to normal arbitration at this edge
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,   // must be >= 1
    parameter int BURST_MAX = DEFAULT_BURST_MAX   // must be >= 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_force,
    input  logic dma_req,
    input  logic cpu_busy,
    input  logic dma_gnt,
    output logic force_enter,
    output logic force_exit
);

    localparam int c_wait_w = $clog2(MAX_WAIT + 1);
    localparam int c_beat_w = $clog2(BURST_MAX + 1);

    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MAX_WAIT - 1);
    localparam logic [c_wait_w-1:0] c_wait_max  = c_wait_w'(MAX_WAIT);
    localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(BURST_MAX - 1);

    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_beat_w-1:0] r_beat_cnt;

    logic w_blocked;
    logic w_last_beat;

    // A blocked cycle is one where DMA asks but the CPU keeps the memory.
    assign w_blocked   = ~in_force & dma_req & cpu_busy & ~dma_gnt;
    assign force_enter = w_blocked & (r_wait_cnt == c_wait_last);

    // The beat that brings the count up to BURST_MAX ends the burst.
    assign w_last_beat = dma_gnt & (r_beat_cnt == c_beat_last);
    assign force_exit  = in_force & (~dma_req | w_last_beat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_beat_cnt <= '0;
        end else if (in_force) begin
            r_wait_cnt <= '0;
            if (force_exit) begin
                r_beat_cnt <= '0;
            end else if (dma_gnt) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end else begin
            r_beat_cnt <= '0;
            if (force_enter) begin
                r_wait_cnt <= '0;
            end else if (w_blocked) begin
                // Saturate rather than wrap so a stuck count never re-arms.
                if (r_wait_cnt != c_wait_max) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                // Either granted or not requesting: starvation restarts.
                r_wait_cnt <= '0;
            end
        end
    end

endmodule : dmem_arb_starve_ctr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the pipeline MEM
//               stage (CPU) and a DMA/debug loader. The CPU has priority; DMA
//               is served in CPU-idle cycles. If DMA is blocked for MAX_WAIT
//               consecutive requesting cycles, a forced burst of up to
//               BURST_MAX beats is granted while cpu_stall freezes the
//               pipeline.
// Ports       : clk, reset                         - clock / async active-low reset
//               cpu_rd, cpu_wr, cpu_addr, cpu_wdata - MEM-stage request
//               cpu_rdata, cpu_stall               - read data / pipeline freeze
//               dma_req, dma_we, dma_addr, dma_wdata - DMA request
//               dma_gnt, dma_rdata, dma_rvalid     - DMA grant / read return
//               mem_rd, mem_wr, mem_addr, mem_wdata, mem_rdata - memory side
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = DEFAULT_AW,
    parameter int DW        = DEFAULT_DW,
    parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,   // must be >= 1
    parameter int BURST_MAX = DEFAULT_BURST_MAX   // must be >= 1
) (
    input  logic          clk,
    input  logic          reset,
    // CPU MEM stage
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    // DMA / debug loader
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    // Data memory
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    r_state;
    logic [DW-1:0] r_dma_rdata;
    logic          r_dma_rvalid;

    logic w_cpu_busy;
    logic w_in_force;
    logic w_gnt;
    logic w_stall;
    logic w_force_enter;
    logic w_force_exit;

    assign w_cpu_busy = cpu_rd | cpu_wr;
    assign w_in_force = (r_state == ST_FORCE);

    // Grant and stall are forced low while reset is held so that nothing
    // reaches the memory or freezes the pipeline during reset.
    assign w_gnt   = reset & dma_req & (w_in_force | ~w_cpu_busy);
    assign w_stall = reset & w_in_force & dma_req & w_cpu_busy;

    assign dma_gnt    = w_gnt;
    assign cpu_stall  = w_stall;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign dma_rvalid = r_dma_rvalid;

    // Memory-side mux. A simultaneous CPU read+write is treated as a write.
    // Strobes are gated by reset so an in-flight write is dropped.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (w_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_wr    = dma_we;
            mem_rd    = ~dma_we;
        end else if (reset) begin
            mem_wr    = cpu_wr;
            mem_rd    = cpu_rd & ~cpu_wr;
        end
    end

    dmem_arb_starve_ctr #(
        .MAX_WAIT  (MAX_WAIT),
        .BURST_MAX (BURST_MAX)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .in_force    (w_in_force),
        .dma_req     (dma_req),
        .cpu_busy    (w_cpu_busy),
        .dma_gnt     (w_gnt),
        .force_enter (w_force_enter),
        .force_exit  (w_force_exit)
    );

    // Arbiter state plus the registered DMA read return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_NORMAL;
            r_dma_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_NORMAL: if (w_force_enter) r_state <= ST_FORCE;
                ST_FORCE:  if (w_force_exit)  r_state <= ST_NORMAL;
                default:   r_state <= ST_NORMAL;
            endcase

            r_dma_rvalid <= w_gnt & ~dma_we;
            if (w_gnt && !dma_we) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

endmodule : dmem_arbiter
`default_nettype wire
